// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared constants for the RV32M multi-cycle execute unit.
//   - INST_* : M-extension funct3 encodings
//   - state_e: FSM state encoding
//   - helpers that classify a funct3 by operand signedness / divide-ness
package ex_muldiv_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic        WRITE_ENABLE = 1'b1;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic op_is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic op1_signed(input logic [2:0] f);
    return (f == INST_MULH) || (f == INST_MULHSU) || (f == INST_DIV) || (f == INST_REM);
  endfunction

  // MULHSU treats rs2 as unsigned.
  function automatic logic op2_signed(input logic [2:0] f);
    return (f == INST_MULH) || (f == INST_DIV) || (f == INST_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// muldiv_iter: one radix-2 iteration of the multiply/divide datapath (combinational).
//   i_is_div : 1 = restoring divide step, 0 = shift-add multiply step
//   i_acc    : multiply {hi partial product, remaining multiplier}
//              divide   {partial remainder, dividend/quotient bits}
//   i_opb    : multiplicand or divisor (magnitude)
//   o_acc    : accumulator after one step
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opb,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rsh;
  logic [XLEN:0] w_diff;

  always_comb begin
    // Multiply: add multiplicand when multiplier LSB is set, then shift the
    // whole accumulator right (carry drops into the top bit).
    w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opb} : {(XLEN+1){1'b0}});
    // Divide: shift next dividend bit into the remainder; remainder < divisor
    // so XLEN+1 bits suffice and bit XLEN of the difference is the borrow.
    w_rsh  = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_diff = w_rsh - {1'b0, i_opb};
    if (i_is_div) begin
      if (!w_diff[XLEN]) o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      else               o_acc = {w_rsh[XLEN-1:0],  i_acc[XLEN-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   clk, rst (sync, active-low)
//   start_i/flush_i      : launch (IDLE only) / abort
//   funct3_i, op1_i, op2_i, reg_waddr_i : operation, operands, destination
//   busy_o               : pipeline stall request
//   done_o/reg_we_o      : one-cycle write-back strobe
//   reg_waddr_o/reg_wdata_o : write-back destination and result
// Operands are reduced to magnitudes at start, iterated XLEN times unsigned,
// and sign-corrected in FIX. Divide-by-zero and signed overflow skip CALC.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_waddr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [XLEN-1:0]     r_opb;
  logic [2:0]          r_funct3;
  logic [4:0]          r_waddr;
  logic                r_neg_q;   // product / quotient sign
  logic                r_neg_r;   // remainder sign (follows dividend)
  logic                r_done;
  logic [XLEN-1:0]     r_wdata;
  logic [4:0]          r_waddr_o;

  logic                w_launch;
  logic                w_s1, w_s2;
  logic [XLEN-1:0]     w_abs1, w_abs2;
  logic                w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]     w_special;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quot, w_rem, w_result;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .i_is_div (op_is_div(r_funct3)),
    .i_acc    (r_acc),
    .i_opb    (r_opb),
    .o_acc    (w_acc_next)
  );

  // ---------------- start decode ----------------
  always_comb begin
    w_launch  = (r_state == S_IDLE) && start_i && !flush_i;
    w_s1      = op1_signed(funct3_i) && op1_i[XLEN-1];
    w_s2      = op2_signed(funct3_i) && op2_i[XLEN-1];
    w_abs1    = w_s1 ? -op1_i : op1_i;
    w_abs2    = w_s2 ? -op2_i : op2_i;
    w_div0    = op_is_div(funct3_i) && (op2_i == '0);
    w_ovf     = ((funct3_i == INST_DIV) || (funct3_i == INST_REM)) &&
                (op1_i == MIN_INT) && (op2_i == '1);
    w_fast    = w_div0 || w_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (w_div0) w_special = funct3_i[1] ? op1_i : '1;
    else        w_special = funct3_i[1] ? '0    : MIN_INT;
  end

  // ---------------- sign fix-up / half select ----------------
  always_comb begin
    w_prod = r_neg_q ? -r_acc : r_acc;
    w_quot = r_neg_q ? -r_acc[XLEN-1:0]      : r_acc[XLEN-1:0];
    w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    case (r_funct3)
      INST_MUL:                      w_result = w_prod[XLEN-1:0];
      INST_MULH, INST_MULHSU,
      INST_MULHU:                    w_result = w_prod[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:           w_result = w_quot;
      default:                       w_result = w_rem;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  // ---------------- datapath / output registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_funct3  <= '0;
      r_waddr   <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_done    <= 1'b0;
      r_wdata   <= XLEN'(ZERO_WORD);
      r_waddr_o <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_launch) begin
          r_funct3 <= funct3_i;
          r_waddr  <= reg_waddr_i;
          r_neg_q  <= w_s1 ^ w_s2;
          r_neg_r  <= w_s1;
          r_acc    <= {{XLEN{1'b0}}, w_abs1};
          r_opb    <= w_abs2;
          r_cnt    <= CNT_W'(XLEN);
          if (w_fast) begin
            r_done    <= WRITE_ENABLE;
            r_wdata   <= w_special;
            r_waddr_o <= reg_waddr_i;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: if (!flush_i) begin
          r_done    <= WRITE_ENABLE;
          r_wdata   <= w_result;
          r_waddr_o <= r_waddr;
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (r_state == S_CALC) || (r_state == S_FIX) || w_launch;
  assign done_o      = r_done;
  assign reg_we_o    = r_done;
  assign reg_waddr_o = r_waddr_o;
  assign reg_wdata_o = r_wdata;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: reference results from 64-bit arithmetic, timing from
// the latency rules, one negedge compare process, plus literal anchors.
module tb_ex_muldiv;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0]  reg_waddr_i;
  logic        busy_o, done_o, reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
    .funct3_i(funct3_i), .op1_i(op1_i), .op2_i(op2_i), .reg_waddr_i(reg_waddr_i),
    .busy_o(busy_o), .done_o(done_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst_q = 1'b0;
  always @(posedge clk) rst_q <= rst;

  // expectation window written by the driver
  int          b_lo = -10, b_hi = -10, d_cyc = -10;
  logic [31:0] exp_data = '0;
  logic [4:0]  exp_waddr = '0;
  logic        lit_valid = 1'b0;
  logic [31:0] lit_val = '0;
  string       lit_name = "";

  int checks = 0, failures = 0;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // single compare process
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (!rst_q) begin
        chk("rst_busy",  32'(busy_o),      32'h0);
        chk("rst_done",  32'(done_o),      32'h0);
        chk("rst_we",    32'(reg_we_o),    32'h0);
        chk("rst_waddr", 32'(reg_waddr_o), 32'h0);
        chk("rst_wdata", reg_wdata_o,      32'h0);
      end else begin
        chk("busy", 32'(busy_o),   32'(cyc >= b_lo && cyc <= b_hi));
        chk("done", 32'(done_o),   32'(cyc == d_cyc));
        chk("we",   32'(reg_we_o), 32'(cyc == d_cyc));
        if (cyc == d_cyc) begin
          chk("wdata", reg_wdata_o,      exp_data);
          chk("waddr", 32'(reg_waddr_o), 32'(exp_waddr));
          if (lit_valid) chk(lit_name, reg_wdata_o, lit_val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // called #1 after a posedge; start edge is the next posedge
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic lv, input logic [31:0] lval, input string nm);
    int lat;
    lat       = is_fast(f, a, b) ? 1 : XLEN + 2;
    exp_data  = model(f, a, b);
    exp_waddr = wa;
    lit_valid = lv; lit_val = lval; lit_name = nm;
    b_lo  = cyc;
    b_hi  = cyc + lat - 1;
    d_cyc = cyc + lat;
    start_i = 1'b1; funct3_i = f; op1_i = a; op2_i = b; reg_waddr_i = wa;
    step();
    // scramble inputs: operands must have been captured
    start_i = 1'b0;
    funct3_i = 3'($urandom); op1_i = $urandom; op2_i = $urandom; reg_waddr_i = 5'($urandom);
  endtask

  task automatic wait_done();
    while (cyc <= d_cyc) step();
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] lval, input string nm);
    launch(f, a, b, wa, 1'b1, lval, nm);
    wait_done();
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int sel;
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; funct3_i = '0;
    op1_i = '0; op2_i = '0; reg_waddr_i = '0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // directed anchors (back-to-back: each starts the cycle after done)
    do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, "mul_7xm3");
    do_op(3'd1, MIN,          MIN,           5'd2,  32'h4000_0000, "mulh_min");
    do_op(3'd3, 32'hFFFF_FFFF,32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, "mulhu_ff");
    do_op(3'd2, 32'hFFFF_FFFF,32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, "mulhsu_ff");
    do_op(3'd4, 32'hFFFF_FFF9,32'd2,         5'd5,  32'hFFFF_FFFD, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9,32'd2,         5'd6,  32'hFFFF_FFFF, "rem_m7_2");
    do_op(3'd5, 32'd100,      32'd7,         5'd7,  32'd14,        "divu_100_7");
    do_op(3'd7, 32'd100,      32'd7,         5'd8,  32'd2,         "remu_100_7");
    do_op(3'd5, 32'd5,        32'd0,         5'd9,  32'hFFFF_FFFF, "divu_by0");
    do_op(3'd7, 32'd5,        32'd0,         5'd10, 32'd5,         "remu_by0");
    do_op(3'd4, MIN,          32'hFFFF_FFFF, 5'd11, MIN,           "div_ovf");
    do_op(3'd6, MIN,          32'hFFFF_FFFF, 5'd12, 32'd0,         "rem_ovf");
    step();

    // flush mid-DIV: no done, busy drops next cycle
    launch(3'd4, 32'd1000, 32'd3, 5'd13, 1'b0, 32'd0, "");
    repeat (8) step();
    flush_i = 1'b1; b_hi = cyc; d_cyc = -10;
    step();
    flush_i = 1'b0;
    repeat (3) step();

    // start+flush together in IDLE launches nothing
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; op1_i = 32'd3; op2_i = 32'd3;
    step();
    start_i = 1'b0; flush_i = 1'b0;
    repeat (3) step();

    // second start during CALC is ignored
    launch(3'd3, 32'h1234_5678, 32'h10, 5'd14, 1'b1, 32'h1, "mulhu_ignore2nd");
    repeat (8) step();
    start_i = 1'b1; funct3_i = 3'd5; op1_i = 32'd9; op2_i = 32'd0; reg_waddr_i = 5'd30;
    step();
    start_i = 1'b0;
    wait_done();

    // reset mid-operation, then a clean operation
    launch(3'd5, 32'd100, 32'd7, 5'd15, 1'b0, 32'd0, "");
    repeat (4) step();
    rst = 1'b0; b_hi = cyc; d_cyc = -10;
    step();
    rst = 1'b1;
    step();
    do_op(3'd7, 32'd100, 32'd7, 5'd16, 32'd2, "remu_after_rst");

    // randomized traffic with biased corner operands and random gaps
    for (int i = 0; i < 150; i++) begin
      f   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a   = $urandom; b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = MIN; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
      else if (sel == 3) b = 32'($urandom_range(1, 9));
      launch(f, a, b, 5'($urandom), 1'b0, 32'd0, "");
      wait_done();
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised multi-cycle execute unit for RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU); sits beside the single-cycle ALU in the EX stage.
- Accepts operands from id_ex on a start pulse and computes one bit per cycle.
- Holds the pipeline through busy_o, then presents a one-cycle register write-back.
- Fast-paths divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand and result width; must be a power of two ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start_i  in  1  launch operation; sampled only in IDLE
- flush_i  in  1  abort the current operation (branch or exception)
- funct3_i  in  3  M-extension funct3 selecting the operation
- op1_i  in  XLEN  rs1 value / dividend
- op2_i  in  XLEN  rs2 value / divisor
- reg_waddr_i  in  5  destination register
- busy_o  out  1  stall request to the pipeline
- done_o  out  1  result valid, one-cycle pulse
- reg_we_o  out  1  write-back enable (equals done_o)
- reg_waddr_o  out  5  captured destination register
- reg_wdata_o  out  XLEN  result

Behaviour:
Reset and idle outputs:
- When rst==0 at a clk edge: state←IDLE; all outputs and internal registers←0.
- Outputs are registered. reg_wdata_o and reg_waddr_o hold their last value outside done, but are only meaningful while done_o==1.

States:
- IDLE: on start_i & ~flush_i, capture funct3, reg_waddr, and sign flags.
  - Capture |op1| and |op2| for the signed variants: MULH uses both signed; MULHSU treats op1 as signed and op2 as unsigned; DIV/REM use both signed.
  - If the op is a divide and op2==0, or the op is signed and op1==-2^(XLEN-1) with op2==-1, go to DONE with the special result.
  - Otherwise go to CALC with counter←XLEN.
- CALC:
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring radix-2 step on a {rem, quot} register.
  - Counter decrements each cycle; move to FIX when counter reaches 1 (exactly XLEN CALC cycles).
- FIX:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend is negative.
  - Select the low or high half according to funct3. Go to DONE.
- DONE: done_o=1, reg_we_o=1 for exactly one cycle, then return to IDLE.

busy_o:
- busy_o=1 in CALC and FIX.
- busy_o=1 in IDLE during the cycle start_i is accepted (combinational on start_i), so the instruction does not leave EX.
- busy_o=0 in DONE.

Latency (start edge to done_o): normal ops XLEN+2 cycles; fast-path ops 1 cycle.

Special results:
- Divide by zero: DIV/DIVU → all ones; REM/REMU → op1.
- Signed overflow: DIV → -2^(XLEN-1); REM → 0.
- MUL returns the low XLEN bits regardless of signedness.

Boundary cases:
- flush_i in any state: next state is IDLE, no done_o, and the result is discarded.
- flush_i together with start_i in IDLE: flush wins and nothing is launched.
- start_i while not in IDLE: ignored.
- Operands are captured at start; later changes on op1_i/op2_i have no effect.
- Reset mid-operation: immediate return to IDLE with outputs zeroed.
- An unused funct3 cannot occur because all eight encodings are defined.

Decomposition:
- Shared defines header:
  - INST_MUL..INST_REMU funct3 constants (000..111).
  - Two-bit state encodings S_IDLE, S_CALC, S_FIX, S_DONE.
  - The existing ZERO_WORD and WRITE_ENABLE constants.
- Sub-module muldiv_iter (XLEN-parametrised): the per-cycle shift-add / restoring-subtract datapath step, purely combinational.
- ex_muldiv owns the FSM, counter, sign logic, and output registers.

Test Plan (XLEN=32):
- MUL 7 × -3 (0xFFFFFFFD) → reg_wdata_o=0xFFFFFFEB; done_o exactly 34 cycles after start; busy_o high throughout until done.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF(-1)×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 % 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- Fast paths: DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 % 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0. Each has done_o 1 cycle after start and busy_o high only in the start cycle.
- Abort and interference:
  - flush_i at cycle 10 of a DIV → no done_o, busy_o low next cycle.
  - A second start_i during CALC is ignored; the first result is unchanged.
  - rst=0 at cycle 5 → all outputs 0 next edge; a new op then completes normally.
- Back-to-back: a new start_i the cycle after done_o → second result correct with latency 34; reg_waddr_o tracks each captured destination.
